wb_register_file: RTL and testbench
===================================

Name: wb_register_file

Overview:
Write-back end of the MEM/WB pipeline interface. Consumes the MEM/WB latch outputs, selects the write-back value, and commits it to a 32-entry architectural register file. Provides two combinational read ports to the ID stage and a committed-write counter for debug and performance.

Parameters:
NBits, 32, datapath and register width
SP_INIT, 32'h7FFFEFFC, reset value of register 29 ($sp)
CNT_BITS, 32, width of the committed-write counter

Ports:
clk  input  1  clock; all state updates on posedge
reset  input  1  asynchronous, active-low reset
MEM_WB_pc_4_i  input  NBits  PC+4 of the retiring instruction
MEM_WB_alu_result_i  input  NBits  ALU result of the retiring instruction
MEM_WB_read_data_i  input  NBits  data-memory load value
MEM_WB_write_register_i  input  5  destination register index
MEM_WB_reg_write_i  input  1  write enable
MEM_WB_mem_to_reg_i  input  2  write-back select
read_register_1_i  input  5  read port 1 index
read_register_2_i  input  5  read port 2 index
read_data_1_o  output  NBits  read port 1 data
read_data_2_o  output  NBits  read port 2 data
wb_data_o  output  NBits  selected write-back value, for forwarding
wb_commit_o  output  1  high when a write commits at the next posedge
commit_count_o  output  CNT_BITS  number of committed writes
sel_error_o  output  1  sticky flag: reserved select seen with write enable high

Behaviour:
- Reset is asynchronous and active-low (reset==0).
- On reset:
  - All registers clear to 0, except register 29, which loads SP_INIT.
  - commit_count_o clears to 0.
  - sel_error_o clears to 0.
- Write-back select, combinational:
  - 2'b00: alu_result
  - 2'b01: read_data
  - 2'b10: pc_4 (jal link)
  - 2'b11: reserved; wb_data_o = alu_result
- wb_commit_o = reg_write & (write_register != 0) & (mem_to_reg != 2'b11).
- Posedge clk, when wb_commit_o is high:
  - regs[write_register] <= wb_data_o.
  - commit_count_o increments by 1 and wraps from all-ones to 0 with no flag.
- Reserved select with reg_write high:
  - No register write and no count increment.
  - sel_error_o sets on the next posedge and stays set until reset.
- Register 0 behaviour:
  - Reads always return 0.
  - A write to register 0 is dropped, does not count, and does not raise an error.
- Read ports are combinational: read_data_N_o = regs[read_register_N_i].
  - Read-during-write returns the old value, unless the optional bypass is compiled in.
- Reset asserted mid-cycle: state clears immediately, and a write pending at that edge is lost.
- Write latency: one cycle. A value is visible on the read ports the cycle after the commit edge.

Optional Feature:
WB_BYPASS_EN.
- Defined: if wb_commit_o is high and read_register_N_i == MEM_WB_write_register_i, then read_data_N_o = wb_data_o in the same cycle (write-first behaviour, removing the WB→ID hazard).
- Undefined: reads return the stored value (read-old); the hazard must be handled by the forwarding unit or by stalls.

Test Plan:
1. Reset, then read indices 0, 29 and 5 → 0, 32'h7FFFEFFC, 0; commit_count_o=0; sel_error_o=0.
2. reg_write=1, mem_to_reg=00, alu=32'h0000002A, dest=8; one clock → read reg 8 = 32'h2A; commit_count_o=1. Repeat with select 01 (read_data=32'hDEADBEEF, dest 9) and select 10 (pc_4=32'h00400010, dest 31) → each value stored; count=3.
3. Write 32'hFFFFFFFF to dest 0 → read reg 0 = 0; count unchanged; sel_error_o=0.
4. mem_to_reg=11, reg_write=1, dest=4 → reg 4 unchanged; count unchanged; sel_error_o=1, still 1 after ten idle cycles; clears only on reset.
5. Same-cycle write of 32'h12345678 to reg 10 with read_register_1_i=10 → read_data_1_o = old value without WB_BYPASS_EN, 32'h12345678 with it; both cases read 32'h12345678 the next cycle.
6. Preload commit_count to all-ones via 2^CNT_BITS−1 commits (or a bench override with CNT_BITS=4: 15 commits), one more commit → count=0. Then assert reset mid-cycle during a pending commit → reg unchanged, count 0.

Source files
------------

// File: rtl/wb_register_file.sv
// wb_register_file: write-back end of the MEM/WB pipeline interface.
// Selects the write-back value, commits it to a 32-entry register file,
// exposes two combinational read ports, a committed-write counter and a
// sticky reserved-select error flag.
// Optional feature macro: WB_BYPASS_EN (write-first read ports).
module wb_register_file #(
    parameter int               NBits    = 32,
    parameter logic [NBits-1:0] SP_INIT  = 32'h7FFFEFFC,
    parameter int               CNT_BITS = 32
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [NBits-1:0]    MEM_WB_pc_4_i,
    input  logic [NBits-1:0]    MEM_WB_alu_result_i,
    input  logic [NBits-1:0]    MEM_WB_read_data_i,
    input  logic [4:0]          MEM_WB_write_register_i,
    input  logic                MEM_WB_reg_write_i,
    input  logic [1:0]          MEM_WB_mem_to_reg_i,
    input  logic [4:0]          read_register_1_i,
    input  logic [4:0]          read_register_2_i,
    output logic [NBits-1:0]    read_data_1_o,
    output logic [NBits-1:0]    read_data_2_o,
    output logic [NBits-1:0]    wb_data_o,
    output logic                wb_commit_o,
    output logic [CNT_BITS-1:0] commit_count_o,
    output logic                sel_error_o
);

    localparam logic [1:0] SEL_ALU  = 2'b00;
    localparam logic [1:0] SEL_MEM  = 2'b01;
    localparam logic [1:0] SEL_PC4  = 2'b10;
    localparam logic [1:0] SEL_RSVD = 2'b11;

    logic [NBits-1:0]    regs_q [32];
    logic [NBits-1:0]    wb_data_d;
    logic                commit_d;
    logic                rsvd_write_d;
    logic [CNT_BITS-1:0] count_q, count_d;
    logic                sel_error_q, sel_error_d;

    // Write-back value select; the reserved encoding falls back to the ALU result.
    always_comb begin
        wb_data_d = MEM_WB_alu_result_i;
        case (MEM_WB_mem_to_reg_i)
            SEL_ALU: wb_data_d = MEM_WB_alu_result_i;
            SEL_MEM: wb_data_d = MEM_WB_read_data_i;
            SEL_PC4: wb_data_d = MEM_WB_pc_4_i;
            default: wb_data_d = MEM_WB_alu_result_i;
        endcase
    end

    // Commit qualification: writes to $zero and reserved selects never commit.
    always_comb begin
        rsvd_write_d = MEM_WB_reg_write_i && (MEM_WB_mem_to_reg_i == SEL_RSVD);
        commit_d     = MEM_WB_reg_write_i
                       && (MEM_WB_write_register_i != 5'd0)
                       && (MEM_WB_mem_to_reg_i != SEL_RSVD);
        count_d      = commit_d ? (count_q + CNT_BITS'(1)) : count_q;
        sel_error_d  = sel_error_q | rsvd_write_d;
    end

    // Architectural register file; $sp comes out of reset at SP_INIT.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            for (int i = 0; i < 32; i++) begin
                regs_q[i] <= (i == 29) ? SP_INIT : '0;
            end
        end else if (commit_d) begin
            regs_q[MEM_WB_write_register_i] <= wb_data_d;
        end
    end

    // Committed-write counter (wraps silently) and sticky select error.
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            count_q     <= '0;
            sel_error_q <= 1'b0;
        end else begin
            count_q     <= count_d;
            sel_error_q <= sel_error_d;
        end
    end

    // Read port 1: $zero reads as 0; optional write-first bypass.
    always_comb begin
        read_data_1_o = (read_register_1_i == 5'd0) ? '0 : regs_q[read_register_1_i];
`ifdef WB_BYPASS_EN
        if (commit_d && (read_register_1_i == MEM_WB_write_register_i)) begin
            read_data_1_o = wb_data_d;
        end
`endif
    end

    // Read port 2: same behaviour as port 1.
    always_comb begin
        read_data_2_o = (read_register_2_i == 5'd0) ? '0 : regs_q[read_register_2_i];
`ifdef WB_BYPASS_EN
        if (commit_d && (read_register_2_i == MEM_WB_write_register_i)) begin
            read_data_2_o = wb_data_d;
        end
`endif
    end

    assign wb_data_o      = wb_data_d;
    assign wb_commit_o    = commit_d;
    assign commit_count_o = count_q;
    assign sel_error_o    = sel_error_q;

endmodule

// File: tb/tb_wb_register_file.sv
// Directed bench for wb_register_file, built with a 4-bit commit counter so
// the wrap-around case is reachable in a handful of cycles.
module tb_wb_register_file;

    localparam int          NB  = 32;
    localparam int          CB  = 4;
    localparam logic [31:0] SPI = 32'h7FFFEFFC;

    logic          clk = 1'b0;
    logic          reset;
    logic [31:0]   pc4, alu, rdat;
    logic [4:0]    wreg;
    logic          we;
    logic [1:0]    sel;
    logic [4:0]    ra1, ra2;
    logic [31:0]   rd1, rd2, wbd;
    logic          commit;
    logic [CB-1:0] cnt;
    logic          serr;

    int checks   = 0;
    int failures = 0;

    wb_register_file #(.NBits(NB), .SP_INIT(SPI), .CNT_BITS(CB)) dut (
        .clk                     (clk),
        .reset                   (reset),
        .MEM_WB_pc_4_i           (pc4),
        .MEM_WB_alu_result_i     (alu),
        .MEM_WB_read_data_i      (rdat),
        .MEM_WB_write_register_i (wreg),
        .MEM_WB_reg_write_i      (we),
        .MEM_WB_mem_to_reg_i     (sel),
        .read_register_1_i       (ra1),
        .read_register_2_i       (ra2),
        .read_data_1_o           (rd1),
        .read_data_2_o           (rd2),
        .wb_data_o               (wbd),
        .wb_commit_o             (commit),
        .commit_count_o          (cnt),
        .sel_error_o             (serr)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            failures++;
            $error("FAIL %s observed=%h expected=%h", tag, obs, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic rd(input logic [4:0] a1, input logic [4:0] a2);
        ra1 = a1;
        ra2 = a2;
        #1;
    endtask

    task automatic wr(input logic [1:0] s, input logic [4:0] d,
                      input logic [31:0] a, input logic [31:0] m, input logic [31:0] p);
        we = 1'b1; sel = s; wreg = d; alu = a; rdat = m; pc4 = p;
        #1;
    endtask

    task automatic idle();
        we = 1'b0; sel = 2'b00; wreg = 5'd0; alu = '0; rdat = '0; pc4 = '0;
        #1;
    endtask

    initial begin
        reset = 1'b0;
        idle();
        ra1 = 5'd0; ra2 = 5'd0;
        repeat (2) tick();
        #2 reset = 1'b1;
        tick();

        // 1: reset state
        rd(5'd0, 5'd29);
        chk("rst_r0", rd1, 32'h0);
        chk("rst_r29", rd2, SPI);
        rd(5'd5, 5'd29);
        chk("rst_r5", rd1, 32'h0);
        chk("rst_cnt", 32'(cnt), 32'd0);
        chk("rst_serr", 32'(serr), 32'd0);
        chk("idle_commit", 32'(commit), 32'd0);

        // 2: three selects
        wr(2'b00, 5'd8, 32'h0000002A, 32'h11111111, 32'h22222222);
        chk("sel00_wbd", wbd, 32'h0000002A);
        chk("sel00_commit", 32'(commit), 32'd1);
        tick(); idle();
        rd(5'd8, 5'd0);
        chk("sel00_r8", rd1, 32'h0000002A);
        chk("sel00_cnt", 32'(cnt), 32'd1);

        wr(2'b01, 5'd9, 32'h33333333, 32'hDEADBEEF, 32'h44444444);
        chk("sel01_wbd", wbd, 32'hDEADBEEF);
        tick(); idle();
        wr(2'b10, 5'd31, 32'h55555555, 32'h66666666, 32'h00400010);
        chk("sel10_wbd", wbd, 32'h00400010);
        tick(); idle();
        rd(5'd9, 5'd31);
        chk("sel01_r9", rd1, 32'hDEADBEEF);
        chk("sel10_r31", rd2, 32'h00400010);
        chk("sel_cnt3", 32'(cnt), 32'd3);

        // 3: write to $zero dropped
        wr(2'b00, 5'd0, 32'hFFFFFFFF, 32'h0, 32'h0);
        chk("r0_commit", 32'(commit), 32'd0);
        tick(); idle();
        rd(5'd0, 5'd8);
        chk("r0_read", rd1, 32'h0);
        chk("r0_cnt", 32'(cnt), 32'd3);
        chk("r0_serr", 32'(serr), 32'd0);

        // 4: reserved select
        wr(2'b00, 5'd4, 32'h00000044, 32'h0, 32'h0);
        tick();
        wr(2'b11, 5'd4, 32'h00000099, 32'h0, 32'h0);
        chk("rsvd_wbd", wbd, 32'h00000099);
        chk("rsvd_commit", 32'(commit), 32'd0);
        chk("rsvd_serr_pre", 32'(serr), 32'd0);
        tick(); idle();
        rd(5'd4, 5'd0);
        chk("rsvd_r4", rd1, 32'h00000044);
        chk("rsvd_cnt", 32'(cnt), 32'd4);
        chk("rsvd_serr", 32'(serr), 32'd1);
        repeat (10) tick();
        chk("rsvd_serr_sticky", 32'(serr), 32'd1);

        // 5: read during write
        rd(5'd10, 5'd10);
        wr(2'b00, 5'd10, 32'h12345678, 32'h0, 32'h0);
`ifdef WB_BYPASS_EN
        chk("rdw_p1_same", rd1, 32'h12345678);
        chk("rdw_p2_same", rd2, 32'h12345678);
`else
        chk("rdw_p1_same", rd1, 32'h0);
        chk("rdw_p2_same", rd2, 32'h0);
`endif
        tick(); idle();
        chk("rdw_p1_next", rd1, 32'h12345678);
        chk("rdw_p2_next", rd2, 32'h12345678);
        chk("rdw_cnt", 32'(cnt), 32'd5);

        // 6: counter wrap, then reset during a pending commit
        for (int i = 0; i < 10; i++) begin
            wr(2'b00, 5'd20, 32'(i), 32'h0, 32'h0);
            tick();
        end
        idle();
        chk("wrap_cnt15", 32'(cnt), 32'd15);
        wr(2'b00, 5'd20, 32'h000000AA, 32'h0, 32'h0);
        tick();
        chk("wrap_cnt0", 32'(cnt), 32'd0);
        tick();
        chk("wrap_cnt1", 32'(cnt), 32'd1);

        wr(2'b00, 5'd13, 32'h0000ABCD, 32'h0, 32'h0);
        #2 reset = 1'b0;
        #1;
        chk("mrst_cnt_now", 32'(cnt), 32'd0);
        tick();
        rd(5'd13, 5'd29);
        chk("mrst_r13", rd1, 32'h0);
        chk("mrst_r29", rd2, SPI);
        chk("mrst_cnt", 32'(cnt), 32'd0);
        chk("mrst_serr", 32'(serr), 32'd0);
        idle();
        #2 reset = 1'b1;
        tick();
        rd(5'd13, 5'd8);
        chk("post_r13", rd1, 32'h0);
        chk("post_r8", rd2, 32'h0);
        chk("post_cnt", 32'(cnt), 32'd0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
